// File: rtl/arb_pkg.sv
// Shared defaults and FSM state encoding for the round-robin bus arbiter.
package arb_pkg;

  localparam int DEFAULT_N_REQ   = 4;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: first set request scanning upward
// from (last_owner_i + 1) mod N_REQ, wrapping around.
module rr_picker
  import arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   last_owner_i,
  output logic             valid_o,
  output logic [IDW-1:0]   winner_o
);

  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDW'((int'(last_owner_i) + k) % N_REQ);
      if (req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a hold timeout; every output comes from a flop.
module bus_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ   = DEFAULT_N_REQ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  arb_state_e      state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  last_owner_q, last_owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            terr_q, terr_d;

  logic            pick_valid;
  logic [IDW-1:0]  pick_winner;
  logic            owner_done;
  logic            timeout_hit;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  assign owner_done  = done[gnt_id_q];
  assign timeout_hit = (cnt_q == CNT_MAX);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    terr_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = GRANT;
          gnt_d    = N_REQ'(1) << pick_winner;
          gnt_id_d = pick_winner;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        // A done strobe on the limit cycle wins over the timeout.
        if (owner_done || timeout_hit) begin
          state_d      = RELEASE;
          gnt_d        = '0;
          busy_d       = 1'b0;
          last_owner_d = gnt_id_q;
          terr_d       = ~owner_done;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      last_owner_q <= IDW'(N_REQ - 1);
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (N_REQ=4, TIMEOUT=16).
module tb_bus_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout_err;

  int tests_run;
  int tests_failed;

  bus_arbiter #(
    .N_REQ   (4),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rstn = 1'b0;
    req  = 4'b0000;
    done = 4'b0000;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = 4'b0000;
    done = 4'b0000;
    repeat (3) @(negedge clk);
    tests_run++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: gnt=%b gnt_id=%0d busy=%b terr=%b required 0000/0/0/0",
               gnt, gnt_id, busy, timeout_err);
    end
    rstn = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_idle_then_single();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_no_req cyc%0d: gnt=%b busy=%b required 0000/0", c, gnt, busy);
      end
    end
    req = 4'b0100;
    @(negedge clk);
    tests_run++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: gnt=%b gnt_id=%0d busy=%b required 0100/2/1", gnt, gnt_id, busy);
    end
    $display("[TB] single request granted gnt=%b id=%0d", gnt, gnt_id);
    done = 4'b0100;
    @(negedge clk);
    done = 4'b0000;
    req  = 4'b0000;
    tests_run++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0 || gnt_id !== 2'd2) begin
      tests_failed++;
      $display("FAIL single_release: gnt=%b busy=%b terr=%b gnt_id=%0d required 0000/0/0/2",
               gnt, busy, timeout_err, gnt_id);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    logic [3:0] exp_gnt;
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_id  = 2'(i % 4);
      exp_gnt = 4'b0001 << exp_id;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        tests_run++;
        if (gnt !== exp_gnt || gnt_id !== exp_id) begin
          tests_failed++;
          $display("FAIL rr_grant%0d cyc%0d: gnt=%b id=%0d required %b/%0d",
                   i, c, gnt, gnt_id, exp_gnt, exp_id);
        end
        if (c == 3) done = exp_gnt;
      end
      $display("[TB] rr grant %0d owner=%0d", i, gnt_id);
      for (int z = 1; z <= 2; z++) begin
        @(negedge clk);
        done = 4'b0000;
        tests_run++;
        if (gnt !== 4'b0000) begin
          tests_failed++;
          $display("FAIL rr_gap%0d_%0d: gnt=%b required 0000", i, z, gnt);
        end
      end
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    req = 4'b0010;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      tests_run++;
      if (gnt !== 4'b0010 || timeout_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_hold cyc%0d: gnt=%b terr=%b required 0010/0", c, gnt, timeout_err);
      end
    end
    @(negedge clk);
    req = 4'b0000;
    tests_run++;
    if (gnt !== 4'b0000 || timeout_err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_release: gnt=%b terr=%b busy=%b required 0000/1/0", gnt, timeout_err, busy);
    end
    $display("[TB] timeout forced release terr=%b", timeout_err);
    @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b0 || gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL timeout_pulse_width: terr=%b gnt=%b required 0/0000", timeout_err, gnt);
    end
  endtask

  task automatic test_done_at_limit();
    req = 4'b0010;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      req = 4'b0000;
      tests_run++;
      if (gnt !== 4'b0010) begin
        tests_failed++;
        $display("FAIL limit_hold cyc%0d: gnt=%b required 0010", c, gnt);
      end
      if (c == 16) done = 4'b0010;
    end
    @(negedge clk);
    done = 4'b0000;
    tests_run++;
    if (gnt !== 4'b0000 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL limit_done_priority: gnt=%b terr=%b required 0000/0", gnt, timeout_err);
    end
    $display("[TB] done on limit cycle terr=%b", timeout_err);
    @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL limit_no_terr: terr=%b required 0", timeout_err);
    end
  endtask

  task automatic test_nonowner_done();
    req = 4'b0010;
    @(negedge clk);
    tests_run++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      tests_failed++;
      $display("FAIL nonowner_grant: gnt=%b id=%0d required 0010/1", gnt, gnt_id);
    end
    req  = 4'b0000;
    done = 4'b1000;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      done = 4'b0000;
      tests_run++;
      if (gnt !== 4'b0010) begin
        tests_failed++;
        $display("FAIL nonowner_hold cyc%0d: gnt=%b required 0010", c, gnt);
      end
    end
    done = 4'b0010;
    @(negedge clk);
    done = 4'b0000;
    tests_run++;
    if (gnt !== 4'b0000 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL nonowner_release: gnt=%b terr=%b required 0000/0", gnt, timeout_err);
    end
    $display("[TB] owner released after own done gnt=%b", gnt);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    tests_run++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL areset_pre_grant: gnt=%b id=%0d required 0001/0", gnt, gnt_id);
    end
    #2 rstn = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0 || gnt_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL areset_async_drop: gnt=%b busy=%b terr=%b id=%0d required 0000/0/0/0",
               gnt, busy, timeout_err, gnt_id);
    end
    @(negedge clk);
    rstn = 1'b1;
    req  = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    tests_run++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_regrant: gnt=%b id=%0d terr=%b required 1000/3/0", gnt, gnt_id, timeout_err);
    end
    $display("[TB] post-reset grant gnt=%b id=%0d", gnt, gnt_id);
    done = 4'b1000;
    @(negedge clk);
    done = 4'b0000;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstn = 1'b0;
    req  = 4'b0000;
    done = 4'b0000;
    test_reset();
    test_idle_then_single();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_nonowner_done();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL take parameter N_REQ, default 4, as the number of requesters (2..8).
REQ-002 The module SHALL take parameter TIMEOUT, default 16, as the maximum number of grant cycles before forced release (≥2).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port req, input, N_REQ bits: level request, one bit per requester.
REQ-006 Port done, input, N_REQ bits: the owner's release strobe, sampled only at the current owner's index.
REQ-007 Port gnt, output, N_REQ bits: registered grant, one-hot or zero.
REQ-008 Port gnt_id, output, $clog2(N_REQ) bits: index of the current or last owner.
REQ-009 Port busy, output, 1 bit: high while in GRANT.
REQ-010 Port timeout_err, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-011 The FSM SHALL have three states, IDLE, GRANT and RELEASE, with the following transitions.
- IDLE→GRANT when req≠0.
- GRANT→RELEASE on done[gnt_id] or timeout.
- RELEASE→IDLE unconditionally.
REQ-012 Selection SHALL be round-robin: the winner is the first set req bit scanning upward from (last_owner+1) mod N_REQ, wrapping.
REQ-013 Grant latency SHALL be 1 cycle: req seen in IDLE at edge k gives gnt high from edge k, visible in cycle k+1.
REQ-014 gnt SHALL remain stable while in GRANT; deasserting req[owner] SHALL NOT release the grant.
REQ-015 Requests arriving or changing during GRANT or RELEASE SHALL have no effect until the next IDLE evaluation.
REQ-016 gnt SHALL be zero in IDLE and RELEASE, so two grants are separated by at least 2 zero-gnt cycles.
REQ-017 A hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-018 When the counter equals TIMEOUT-1 with done[owner]=0, the FSM SHALL exit to RELEASE and pulse timeout_err for exactly the RELEASE cycle.
REQ-019 If done[owner] and the timeout condition coincide, done SHALL take priority and timeout_err SHALL stay 0.
REQ-020 done bits at non-owner indices, and all done bits outside GRANT, SHALL be ignored.
REQ-021 last_owner SHALL update to gnt_id on the GRANT→RELEASE transition; gnt_id SHALL hold that value through RELEASE and IDLE.
REQ-022 The counter SHALL saturate and not wrap; its width SHALL be $clog2(TIMEOUT).

Reset
REQ-023 On rstn low the block SHALL asynchronously force the following, independent of clk.
- state=IDLE, gnt=0, gnt_id=0, busy=0, timeout_err=0, counter=0.
- last_owner=N_REQ-1, so requester 0 has first priority.
REQ-024 Reset asserted mid-GRANT SHALL drop gnt immediately, with no timeout_err.
REQ-025 After rstn rises, the first arbitration SHALL occur on the first clk edge with req≠0.

Structure
REQ-026 Package arb_pkg SHALL hold the default N_REQ and TIMEOUT localparams and the state enum typedef (IDLE, GRANT, RELEASE).
REQ-027 Rotating priority selection SHALL be a combinational sub-module rr_picker, with inputs req and last_owner and outputs valid and winner index.
REQ-028 The FSM, counter and output registers SHALL reside in bus_arbiter; all outputs SHALL be driven from flops.

Verification
REQ-029 Release rstn with req=4'b0000 -> gnt=0 and busy=0 indefinitely; then req=4'b0100 -> gnt=4'b0100 and gnt_id=2 one cycle later.
REQ-030 Hold req=4'b1111 and pulse done[owner] 3 cycles into each grant -> grant order 0,1,2,3,0 with exactly 2 zero-gnt cycles between grants.
REQ-031 Hold req=4'b0010 and never pulse done -> gnt held exactly 16 cycles, then gnt=0 and a single-cycle timeout_err.
REQ-032 Assert done[owner] in grant cycle 16 (counter=15) -> normal release and timeout_err=0.
REQ-033 Owner 1 granted, then req[1] drops and done[3] pulses -> gnt stays 4'b0010 until done[1].
REQ-034 rstn low during GRANT -> gnt=0 asynchronously before the next edge; after release with req=4'b1000, requester 3 is granted and gnt_id=3.
